mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the datapath's instruction and data request interfaces.
- Serves imem/dmem read and write requests from one internal word-addressed single-port RAM, with a parameterised access latency.
- Returns single-cycle ihit/dhit pulses together with load data.
- Arbitrates between the two request streams, handles byte/half/word access widths, and provides a preload port for bench and boot image loading.

Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to hit pulse; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_ren  in  1  instruction fetch request, level.
- imem_addr  in  32  fetch byte address.
- imem_load  out  32  fetched word, valid when ihit=1.
- ihit  out  1  fetch complete, single-cycle pulse.
- dmem_ren  in  1  data read request, level.
- dmem_wen  in  1  data write request, level.
- dmem_addr  in  32  data byte address.
- dmem_store  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- dmem_width  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- dmem_load  out  32  load data, right-aligned, zero-filled above the access width; valid when dhit=1.
- dhit  out  1  data access complete, single-cycle pulse.
- misalign_err  out  1  pulses with dhit when the data access was misaligned.
- busy  out  1  high while a transaction is in flight.
- pre_wen  in  1  preload write, whole word.
- pre_addr  in  ADDR_W  preload word index.
- pre_wdat  in  32  preload data.

Behaviour:
- Reset (rst=1 at a rising edge): FSM goes to IDLE, counter cleared, and all outputs go to 0 (ihit, dhit, imem_load, dmem_load, misalign_err, busy). RAM contents are not cleared. Reset mid-transaction aborts it: no hit, no write.
- FSM states: IDLE, WAIT, RESP.
- IDLE, acceptance: at each rising edge in IDLE with any request asserted, latch the request (type, address, store data, width) and set busy.
  - Data has priority over instruction: if dmem_ren|dmem_wen is asserted, the data request wins; otherwise imem_ren is served.
  - If dmem_ren and dmem_wen are both set, treat as a write; dmem_load returns 0.
- IDLE, next state: if LATENCY=1, go to RESP; otherwise go to WAIT with counter = LATENCY-1.
- WAIT: decrement the counter each cycle; move to RESP when the counter reaches 1.
- RESP:
  - The hit for the latched type is asserted combinationally for exactly one cycle; load data is valid in that cycle.
  - A write commits to RAM at the rising edge ending RESP.
  - Go to IDLE. busy drops at that edge.
- Timing: a request accepted at edge t produces its hit in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Back-to-back: a new request can be accepted at the first edge after RESP. An instruction request pending during a data transaction is served next.
- Requests withdrawn or changed after acceptance are ignored; the latched transaction still completes and still pulses its hit.
- Address decode: word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2**ADDR_W words.
- Loads: select the byte at addr[1:0] or the half at addr[1], shift it to bit 0, and zero-fill above it. Sign extension is the datapath's job.
- Stores: byte-enable merge into the addressed word (read-modify-write on the latched word). Unselected bytes are unchanged.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - No RAM write, dmem_load=0.
  - dhit and misalign_err both pulse in RESP.
- Instruction fetches always read the whole word; addr[1:0] is ignored.
- Preload: honoured only in IDLE with no request being accepted in that cycle. pre_wen in any other state, or in the same cycle as a request, is dropped.
- Hit outputs are never both high in the same cycle.

Test Plan:
- Reset, then preload word 4 = 32'hDEADBEEF; imem_ren with imem_addr=32'h10 → ihit exactly 2 cycles after acceptance, imem_load=32'hDEADBEEF, busy high for 2 cycles.
- dmem_ren with width 00, addr 32'h13 → dmem_load=32'h000000DE. Width 01, addr 32'h12 → 32'h0000DEAD.
- dmem_wen with width 00, addr 32'h11, store 32'h55 → then a word read of 32'h10 returns 32'hDEAD55EF.
- imem_ren and dmem_ren asserted in the same cycle → dhit first, then ihit LATENCY cycles after dhit+1. The pulses never overlap.
- Word write to addr 32'h12 with store 32'h12345678 → dhit and misalign_err pulse; word 4 unchanged.
- rst asserted in the WAIT cycle of a write → no dhit, no RAM change, outputs 0 on the next cycle.
- LATENCY=1 build: back-to-back fetches with imem_ren held high → ihit on every second cycle.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: serves instruction and data requests from one
// word-addressed single-port RAM with a fixed access latency.
module mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_ren,
    input  logic [31:0]       imem_addr,
    output logic [31:0]       imem_load,
    output logic              ihit,
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [31:0]       dmem_addr,
    input  logic [31:0]       dmem_store,
    input  logic [1:0]        dmem_width,
    output logic [31:0]       dmem_load,
    output logic              dhit,
    output logic              misalign_err,
    output logic              busy,
    input  logic              pre_wen,
    input  logic [ADDR_W-1:0] pre_addr,
    input  logic [31:0]       pre_wdat
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                is_data_q, is_data_d;
    logic                is_wr_q, is_wr_d;
    logic                mis_q, mis_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [1:0]          width_q, width_d;
    logic [31:0]         store_q, store_d;
    logic [31:0]         rdata_q;

    logic [31:0]         ram [2**ADDR_W];

    logic                dreq;
    logic                accept;
    logic [ADDR_W-1:0]   rd_idx;
    logic                ram_we;
    logic                pre_we;
    logic [31:0]         ld_data;
    logic [31:0]         wdata;
    logic [31:0]         shifted;
    logic [31:0]         sdata;
    logic [3:0]          be;
    logic                unused_addr_bits;

    assign dreq   = dmem_ren | dmem_wen;
    assign rd_idx = dreq ? dmem_addr[ADDR_W+1:2] : imem_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{imem_addr[31:ADDR_W+2], dmem_addr[31:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_data_q <= 1'b0;
            is_wr_q   <= 1'b0;
            mis_q     <= 1'b0;
            addr_q    <= '0;
            width_q   <= '0;
            store_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_data_q <= is_data_d;
            is_wr_q   <= is_wr_d;
            mis_q     <= mis_d;
            addr_q    <= addr_d;
            width_q   <= width_d;
            store_q   <= store_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_data_d    = is_data_q;
        is_wr_d      = is_wr_q;
        mis_d        = mis_q;
        addr_d       = addr_q;
        width_d      = width_q;
        store_d      = store_q;
        accept       = 1'b0;
        ihit         = 1'b0;
        dhit         = 1'b0;
        misalign_err = 1'b0;
        imem_load    = '0;
        dmem_load    = '0;
        busy         = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (dreq || imem_ren) begin
                    accept    = 1'b1;
                    is_data_d = dreq;
                    is_wr_d   = dmem_wen;
                    addr_d    = dreq ? dmem_addr[ADDR_W+1:0] : imem_addr[ADDR_W+1:0];
                    width_d   = dmem_width;
                    store_d   = dmem_store;
                    case (dmem_width)
                        2'b00:   mis_d = 1'b0;
                        2'b01:   mis_d = dreq & dmem_addr[0];
                        default: mis_d = dreq & (dmem_addr[1:0] != 2'b00);
                    endcase
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (is_data_q) begin
                    dhit         = 1'b1;
                    misalign_err = mis_q;
                    if (!is_wr_q && !mis_q) dmem_load = ld_data;
                end else begin
                    ihit      = 1'b1;
                    imem_load = rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load extraction and byte-lane store merge, both from the word read at acceptance.
    always_comb begin
        shifted = rdata_q >> {addr_q[1:0], 3'b000};
        case (width_q)
            2'b00: begin
                ld_data = {24'b0, shifted[7:0]};
                be      = 4'b0001 << addr_q[1:0];
                sdata   = {4{store_q[7:0]}};
            end
            2'b01: begin
                ld_data = addr_q[1] ? {16'b0, rdata_q[31:16]} : {16'b0, rdata_q[15:0]};
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                sdata   = {2{store_q[15:0]}};
            end
            default: begin
                ld_data = rdata_q;
                be      = 4'b1111;
                sdata   = store_q;
            end
        endcase
        wdata = rdata_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) wdata[8*i +: 8] = sdata[8*i +: 8];
        end
    end

    assign ram_we = (state_q == RESP) && is_data_q && is_wr_q && !mis_q && !rst;
    assign pre_we = (state_q == IDLE) && !accept && pre_wen && !rst;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[addr_q[ADDR_W+1:2]] <= wdata;
        end else if (pre_we) begin
            ram[pre_addr] <= pre_wdat;
        end
        if (accept) rdata_q <= ram[rd_idx];
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural memory model.
module tb_mem_responder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_ren, dmem_ren, dmem_wen, pre_wen;
    logic [31:0]   imem_addr, dmem_addr, dmem_store, pre_wdat;
    logic [1:0]    dmem_width;
    logic [AW-1:0] pre_addr;
    logic [31:0]   imem_load, dmem_load;
    logic          ihit, dhit, misalign_err, busy;

    logic          u1_imem_ren, u1_dmem_ren, u1_dmem_wen, u1_pre_wen;
    logic [31:0]   u1_imem_addr, u1_dmem_addr, u1_dmem_store, u1_pre_wdat;
    logic [1:0]    u1_dmem_width;
    logic [AW-1:0] u1_pre_addr;
    logic [31:0]   u1_imem_load, u1_dmem_load;
    logic          u1_ihit, u1_dhit, u1_misalign_err, u1_busy;

    int passed = 0;
    int total  = 0;
    logic [31:0] model [16];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(AW), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_load(imem_load), .ihit(ihit),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_store(dmem_store), .dmem_width(dmem_width), .dmem_load(dmem_load),
        .dhit(dhit), .misalign_err(misalign_err), .busy(busy),
        .pre_wen(pre_wen), .pre_addr(pre_addr), .pre_wdat(pre_wdat)
    );

    mem_responder #(.ADDR_W(AW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .imem_ren(u1_imem_ren), .imem_addr(u1_imem_addr), .imem_load(u1_imem_load), .ihit(u1_ihit),
        .dmem_ren(u1_dmem_ren), .dmem_wen(u1_dmem_wen), .dmem_addr(u1_dmem_addr),
        .dmem_store(u1_dmem_store), .dmem_width(u1_dmem_width), .dmem_load(u1_dmem_load),
        .dhit(u1_dhit), .misalign_err(u1_misalign_err), .busy(u1_busy),
        .pre_wen(u1_pre_wen), .pre_addr(u1_pre_addr), .pre_wdat(u1_pre_wdat)
    );

    typedef struct {
        int          kind;      // 0 fetch, 1 read, 2 write, 3 read+write
        logic [31:0] addr;
        logic [31:0] st;
        logic [1:0]  width;
        logic [31:0] exp_load;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic preload(input logic [AW-1:0] idx, input logic [31:0] dat);
        pre_wen  = 1'b1;
        pre_addr = idx;
        pre_wdat = dat;
        step();
        pre_wen  = 1'b0;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] width,
                                             input logic [1:0] off);
        case (width)
            2'd0:    return (w >> (8 * int'(off))) & 32'hFF;
            2'd1:    return (w >> (16 * int'(off[1]))) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [1:0] width, input logic [1:0] off);
        if (width == 2'd0) return 1'b0;
        if (width == 2'd1) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] st,
                                              input logic [1:0] width, input logic [1:0] off);
        int unsigned nbytes;
        int unsigned pos;
        nbytes = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
        for (int unsigned b = 0; b < nbytes; b++) begin
            pos = int'(off) + b;
            w = (w & ~(32'hFF << (8 * pos))) | (((st >> (8 * b)) & 32'hFF) << (8 * pos));
        end
        return w;
    endfunction

    // Issue one request, scramble the inputs after acceptance, wait for its hit.
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] st,
                          input logic [1:0] width, output logic [31:0] load, output logic mis,
                          output int lat, output int busyc, output int wrong);
        logic got, other;
        imem_ren   = (kind == 0);
        dmem_ren   = (kind == 1) || (kind == 3);
        dmem_wen   = (kind >= 2);
        imem_addr  = addr;
        dmem_addr  = addr;
        dmem_store = st;
        dmem_width = width;
        step();
        imem_ren   = 1'b0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        pre_wen    = 1'b0;
        imem_addr  = $urandom();
        dmem_addr  = $urandom();
        dmem_store = $urandom();
        dmem_width = 2'($urandom());
        lat = 1; busyc = 0; wrong = 0; load = '0; mis = 1'b0;
        forever begin
            busyc += int'(busy);
            got   = (kind == 0) ? ihit : dhit;
            other = (kind == 0) ? dhit : ihit;
            if (other) wrong++;
            if (misalign_err && !dhit) wrong++;
            if (got) begin
                load = (kind == 0) ? imem_load : dmem_load;
                mis  = misalign_err;
                break;
            end
            if (lat >= 20) begin
                lat = 99;
                break;
            end
            step();
            lat++;
        end
        step();
        if (ihit || dhit || busy) wrong++;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ld, dl, il, r, exp_ld;
        logic        ms, exp_ms;
        logic [11:0] pat;
        logic [3:0]  idx;
        logic [1:0]  off, wd;
        int          lat, bc, wr, dcyc, icyc, overlap, cnt, kind;

        rst = 1'b1;
        imem_ren = 0; dmem_ren = 0; dmem_wen = 0; pre_wen = 0;
        imem_addr = '0; dmem_addr = '0; dmem_store = '0; pre_wdat = '0;
        dmem_width = '0; pre_addr = '0;
        u1_imem_ren = 0; u1_dmem_ren = 0; u1_dmem_wen = 0; u1_pre_wen = 0;
        u1_imem_addr = '0; u1_dmem_addr = '0; u1_dmem_store = '0; u1_pre_wdat = '0;
        u1_dmem_width = '0; u1_pre_addr = '0;
        step();
        step();
        check("rst_ihit", {31'b0, ihit}, 0);
        check("rst_dhit", {31'b0, dhit}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_mis", {31'b0, misalign_err}, 0);
        check("rst_imem_load", imem_load, 0);
        check("rst_dmem_load", dmem_load, 0);
        rst = 1'b0;
        step();

        preload(4, 32'hDEADBEEF);
        preload(5, 32'h55555555);
        preload(6, 32'h60606060);
        preload(8, 32'h0BADF00D);

        vecs[0]  = '{0, 32'h10,   32'h0,        2'b10, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1, 32'h13,   32'h0,        2'b00, 32'h000000DE, 1'b0};
        vecs[2]  = '{1, 32'h12,   32'h0,        2'b01, 32'h0000DEAD, 1'b0};
        vecs[3]  = '{2, 32'h11,   32'h55,       2'b00, 32'h0,        1'b0};
        vecs[4]  = '{1, 32'h10,   32'h0,        2'b10, 32'hDEAD55EF, 1'b0};
        vecs[5]  = '{2, 32'h12,   32'h12345678, 2'b10, 32'h0,        1'b1};
        vecs[6]  = '{1, 32'h10,   32'h0,        2'b10, 32'hDEAD55EF, 1'b0};
        vecs[7]  = '{1, 32'h11,   32'h0,        2'b01, 32'h0,        1'b1};
        vecs[8]  = '{1, 32'h10,   32'h0,        2'b11, 32'hDEAD55EF, 1'b0};
        vecs[9]  = '{0, 32'h13,   32'h0,        2'b00, 32'hDEAD55EF, 1'b0};
        vecs[10] = '{1, 32'h1010, 32'h0,        2'b10, 32'hDEAD55EF, 1'b0};
        vecs[11] = '{3, 32'h10,   32'hFFFFFFAA, 2'b00, 32'h0,        1'b0};
        vecs[12] = '{1, 32'h10,   32'h0,        2'b10, 32'hDEAD55AA, 1'b0};
        vecs[13] = '{2, 32'h12,   32'h9999BEEF, 2'b01, 32'h0,        1'b0};
        vecs[14] = '{1, 32'h10,   32'h0,        2'b10, 32'hBEEF55AA, 1'b0};
        vecs[15] = '{1, 32'h11,   32'h0,        2'b00, 32'h00000055, 1'b0};

        for (int i = 0; i < 16; i++) begin
            do_txn(vecs[i].kind, vecs[i].addr, vecs[i].st, vecs[i].width, ld, ms, lat, bc, wr);
            check($sformatf("vec%0d_load", i), ld, vecs[i].exp_load);
            check($sformatf("vec%0d_mis", i), {31'b0, ms}, {31'b0, vecs[i].exp_mis});
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_busy_cycles", i), bc, 2);
            check($sformatf("vec%0d_protocol", i), wr, 0);
        end

        // Simultaneous fetch and data read: data first, fetch follows.
        imem_ren = 1; imem_addr = 32'h14;
        dmem_ren = 1; dmem_addr = 32'h10; dmem_width = 2'b10;
        dcyc = -1; icyc = -1; overlap = 0; dl = '0; il = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 0) dmem_ren = 0;
            if (ihit && dhit) overlap++;
            if (dhit && dcyc < 0) begin dcyc = c; dl = dmem_load; end
            if (ihit && icyc < 0) begin icyc = c; il = imem_load; imem_ren = 0; end
        end
        check("arb_dhit_cycle", dcyc, 1);
        check("arb_ihit_cycle", icyc, 4);
        check("arb_overlap", overlap, 0);
        check("arb_dmem_load", dl, 32'hBEEF55AA);
        check("arb_imem_load", il, 32'h55555555);

        // Preload in the same cycle as a request, and during WAIT/RESP, is dropped.
        pre_wen = 1; pre_addr = 5; pre_wdat = 32'h11111111;
        do_txn(0, 32'h14, 32'h0, 2'b10, ld, ms, lat, bc, wr);
        check("pre_same_cycle_fetch", ld, 32'h55555555);
        imem_ren = 1; imem_addr = 32'h18;
        step();
        imem_ren = 0;
        pre_wen = 1; pre_addr = 6; pre_wdat = 32'h66666666;
        step();
        check("pre_busy_ihit", {31'b0, ihit}, 1);
        check("pre_busy_load", imem_load, 32'h60606060);
        step();
        pre_wen = 0;
        do_txn(1, 32'h18, 32'h0, 2'b10, ld, ms, lat, bc, wr);
        check("pre_busy_dropped", ld, 32'h60606060);
        do_txn(1, 32'h14, 32'h0, 2'b10, ld, ms, lat, bc, wr);
        check("pre_same_cycle_dropped", ld, 32'h55555555);

        // Reset during WAIT of a write aborts it.
        dmem_wen = 1; dmem_addr = 32'h20; dmem_store = 32'hCAFEF00D; dmem_width = 2'b10;
        step();
        dmem_wen = 0;
        rst = 1;
        step();
        rst = 0;
        check("abort_outputs", {ihit, dhit, misalign_err, busy}, 4'b0);
        check("abort_loads", imem_load | dmem_load, 0);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (dhit || busy) cnt++;
        end
        check("abort_no_hit", cnt, 0);
        do_txn(1, 32'h20, 32'h0, 2'b10, ld, ms, lat, bc, wr);
        check("abort_ram_unchanged", ld, 32'h0BADF00D);

        // LATENCY=1 instance: held fetch gives a hit every second cycle.
        u1_pre_wen = 1; u1_pre_addr = 0; u1_pre_wdat = 32'hA5A5A5A5;
        step();
        u1_pre_wen = 0;
        u1_imem_ren = 1; u1_imem_addr = 32'h0;
        pat = '0; cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            pat[i] = u1_ihit;
            if (u1_ihit && u1_imem_load !== 32'hA5A5A5A5) cnt++;
            if (u1_dhit) cnt++;
        end
        u1_imem_ren = 0;
        step();
        step();
        check("lat1_hit_pattern", {20'b0, pat}, 32'h555);
        check("lat1_load", cnt, 0);

        // Randomized traffic against the memory model.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom();
            preload(AW'(i), model[i]);
        end
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = 4'($urandom());
                r   = $urandom();
                model[idx] = r;
                preload({6'b0, idx}, r);
            end
            kind = $urandom_range(0, 3);
            idx  = 4'($urandom());
            off  = 2'($urandom());
            wd   = 2'($urandom());
            r    = $urandom();
            r    = {r[31:12], 6'b0, idx, off};
            dl   = $urandom();
            if (kind == 0) begin
                exp_ld = model[idx];
                exp_ms = 1'b0;
            end else begin
                exp_ms = ref_mis(wd, off);
                exp_ld = (kind >= 2 || exp_ms) ? 32'h0 : ref_load(model[idx], wd, off);
                if (kind >= 2 && !exp_ms) model[idx] = ref_store(model[idx], dl, wd, off);
            end
            do_txn(kind, r, dl, wd, ld, ms, lat, bc, wr);
            check($sformatf("rnd%0d_k%0d_w%0d_a%h_load", n, kind, wd, r), ld, exp_ld);
            check($sformatf("rnd%0d_mis", n), {31'b0, ms}, {31'b0, exp_ms});
            check($sformatf("rnd%0d_latency", n), lat, 2);
            check($sformatf("rnd%0d_protocol", n), wr, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
